// File: rtl/axi_lite_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_regfile_pkg
//  Description : Register map, response codes and address decode helpers
//                shared by the multi-channel AXI4-Lite register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_regfile_pkg;

  localparam logic [31:0] VERSION_DEFAULT = 32'h0002_0000;

  // Global register offsets
  localparam logic [31:0] OFF_VERSION  = 32'h000;
  localparam logic [31:0] OFF_CTRL     = 32'h004;
  localparam logic [31:0] OFF_SCRATCH  = 32'h008;
  localparam logic [31:0] OFF_IRQ_EN   = 32'h00C;
  localparam logic [31:0] OFF_IRQ_STAT = 32'h010;

  // Per-channel window geometry; the stride is a power of two so the window
  // offset is simply the low address bits.
  localparam logic [31:0] CH_BASE   = 32'h100;
  localparam logic [31:0] CH_STRIDE = 32'h020;
  localparam int          CH_SHIFT  = 5;

  // Offsets inside a channel window
  localparam logic [31:0] CH_OFF_C2H_WR_NEXT  = 32'h00;
  localparam logic [31:0] CH_OFF_C2H_RD_NEXT  = 32'h04;
  localparam logic [31:0] CH_OFF_H2C_RD_NEXT  = 32'h08;
  localparam logic [31:0] CH_OFF_H2C_WR_NEXT  = 32'h0C;
  localparam logic [31:0] CH_OFF_H2C_FRM_SIZE = 32'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_VERSION,
    SEL_CTRL,
    SEL_SCRATCH,
    SEL_IRQ_EN,
    SEL_IRQ_STAT,
    SEL_C2H_WR_NEXT,
    SEL_C2H_RD_NEXT,
    SEL_H2C_RD_NEXT,
    SEL_H2C_WR_NEXT,
    SEL_H2C_FRM_SIZE
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] ch;
  } reg_dec_t;

  // Map a byte address to a register; misaligned, unmapped and out-of-range
  // channel addresses all come back as SEL_NONE.
  function automatic reg_dec_t decode_addr(input logic [31:0] addr, input int unsigned num_ch);
    reg_dec_t    d;
    logic [31:0] rel;
    logic [31:0] idx;
    logic [31:0] off;
    d.sel = SEL_NONE;
    d.ch  = 3'd0;
    rel   = addr - CH_BASE;
    idx   = rel >> CH_SHIFT;
    off   = rel & (CH_STRIDE - 32'd1);
    if (addr[1:0] == 2'b00) begin
      if (addr < CH_BASE) begin
        case (addr)
          OFF_VERSION:  d.sel = SEL_VERSION;
          OFF_CTRL:     d.sel = SEL_CTRL;
          OFF_SCRATCH:  d.sel = SEL_SCRATCH;
          OFF_IRQ_EN:   d.sel = SEL_IRQ_EN;
          OFF_IRQ_STAT: d.sel = SEL_IRQ_STAT;
          default:      d.sel = SEL_NONE;
        endcase
      end else if (idx < num_ch) begin
        d.ch = idx[2:0];
        case (off)
          CH_OFF_C2H_WR_NEXT:  d.sel = SEL_C2H_WR_NEXT;
          CH_OFF_C2H_RD_NEXT:  d.sel = SEL_C2H_RD_NEXT;
          CH_OFF_H2C_RD_NEXT:  d.sel = SEL_H2C_RD_NEXT;
          CH_OFF_H2C_WR_NEXT:  d.sel = SEL_H2C_WR_NEXT;
          CH_OFF_H2C_FRM_SIZE: d.sel = SEL_H2C_FRM_SIZE;
          default:             d.sel = SEL_NONE;
        endcase
      end
    end
    return d;
  endfunction

  // Byte-strobed merge of new write data into an existing register value
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val, input logic [31:0] new_val,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_slv_core.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_slv_core
//  Description : AXI4-Lite slave handshake engine. Holds AW and W
//                independently, commits one write at a time and returns
//                single-beat read responses with registered data.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_slv_core
  import axi_lite_regfile_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_aresetn,
  input  logic [ADDR_BITS-1:0] s_axi_awaddr,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [31:0]          s_axi_wdata,
  input  logic [3:0]           s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [ADDR_BITS-1:0] s_axi_araddr,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [31:0]          s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [31:0]          wr_data,
  output logic [3:0]           wr_be,
  input  logic                 wr_err,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [31:0]          rd_data,
  input  logic                 rd_err
);

  logic                 r_ready_en;
  logic                 r_aw_held;
  logic                 r_w_held;
  logic [ADDR_BITS-1:0] r_aw_addr;
  logic [31:0]          r_w_data;
  logic [3:0]           r_w_strb;
  logic                 r_bvalid;
  logic [1:0]           r_bresp;
  logic                 r_rvalid;
  logic [1:0]           r_rresp;
  logic [31:0]          r_rdata;

  // Readies stay low while reset is held and come up the cycle after release
  assign s_axi_awready = r_ready_en & ~r_aw_held & ~r_bvalid;
  assign s_axi_wready  = r_ready_en & ~r_w_held & ~r_bvalid;
  assign s_axi_arready = r_ready_en & ~r_rvalid;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;

  assign wr_en   = r_aw_held & r_w_held & ~r_bvalid;
  assign wr_addr = r_aw_addr;
  assign wr_data = r_w_data;
  assign wr_be   = r_w_strb;

  assign rd_en   = s_axi_arvalid & s_axi_arready;
  assign rd_addr = s_axi_araddr;

  // Write channel: capture AW/W independently, commit once both are held
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_ready_en <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_addr  <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_ready_en <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        r_w_held <= 1'b1;
        r_w_data <= s_axi_wdata;
        r_w_strb <= s_axi_wstrb;
      end
      if (wr_en) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && s_axi_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read channel: data captured on the AR handshake, held until RREADY
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (rd_en) begin
      r_rvalid <= 1'b1;
      r_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      r_rdata  <= rd_err ? 32'd0 : rd_data;
    end else if (r_rvalid && s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_lite_multich_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_multich_regfile
//  Description : AXI4-Lite register file with per-channel C2H/H2C frame
//                pointer windows, global control/scratch registers and a
//                sticky W1C frame-done interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_multich_regfile
  import axi_lite_regfile_pkg::*;
#(
  parameter int          ADDR_BITS = 16,
  parameter int          NUM_CH    = 4,
  parameter logic [31:0] VERSION   = VERSION_DEFAULT
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [ADDR_BITS-1:0]  s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_BITS-1:0]  s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  soft_reset,
  output logic                  irq,
  input  logic [NUM_CH*32-1:0]  c2h_wr_next,
  input  logic [NUM_CH*32-1:0]  h2c_rd_next,
  input  logic [NUM_CH-1:0]     c2h_done,
  input  logic [NUM_CH-1:0]     h2c_done,
  output logic [NUM_CH*32-1:0]  c2h_rd_next,
  output logic [NUM_CH*32-1:0]  h2c_wr_next,
  output logic [NUM_CH*32-1:0]  h2c_frm_size
);

  localparam int IRQ_W = 2 * NUM_CH;

  logic                 w_wr_en;
  logic [ADDR_BITS-1:0] w_wr_addr;
  logic [31:0]          w_wr_data;
  logic [3:0]           w_wr_be;
  logic                 w_wr_err;
  logic                 w_rd_en;
  logic [ADDR_BITS-1:0] w_rd_addr;
  logic [31:0]          w_rd_data;
  logic                 w_rd_err;

  reg_dec_t             w_wr_dec;
  reg_dec_t             w_rd_dec;
  logic                 w_wr_ok;

  logic [31:0]          r_scratch;
  logic [31:0]          r_irq_en;
  logic [IRQ_W-1:0]     r_irq_stat;
  logic [IRQ_W-1:0]     w_irq_stat_next;
  logic [IRQ_W-1:0]     w_irq_clr;
  logic [IRQ_W-1:0]     w_done_vec;
  logic                 r_irq;
  logic                 r_soft_reset;

  axi_lite_slv_core #(
    .ADDR_BITS (ADDR_BITS)
  ) u_core (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .wr_en         (w_wr_en),
    .wr_addr       (w_wr_addr),
    .wr_data       (w_wr_data),
    .wr_be         (w_wr_be),
    .wr_err        (w_wr_err),
    .rd_en         (w_rd_en),
    .rd_addr       (w_rd_addr),
    .rd_data       (w_rd_data),
    .rd_err        (w_rd_err)
  );

  assign w_wr_dec = decode_addr(32'(w_wr_addr), NUM_CH);
  assign w_rd_dec = decode_addr(32'(w_rd_addr), NUM_CH);

  // Writes to read-only registers are rejected; CTRL is write-only
  assign w_wr_err = (w_wr_dec.sel == SEL_NONE) || (w_wr_dec.sel == SEL_VERSION) ||
                    (w_wr_dec.sel == SEL_C2H_WR_NEXT) || (w_wr_dec.sel == SEL_H2C_RD_NEXT);
  assign w_rd_err = (w_rd_dec.sel == SEL_NONE) || (w_rd_dec.sel == SEL_CTRL);
  assign w_wr_ok  = w_wr_en & ~w_wr_err;

  assign soft_reset = r_soft_reset;
  assign irq        = r_irq;

  // Interleave done pulses: bit 2n is C2H, bit 2n+1 is H2C of channel n
  always_comb begin
    w_done_vec = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      w_done_vec[2*n]   = c2h_done[n];
      w_done_vec[2*n+1] = h2c_done[n];
    end
  end

  // W1C clear mask (byte-strobed), then sticky set which overrides the clear
  always_comb begin
    w_irq_clr = '0;
    if (w_wr_ok && (w_wr_dec.sel == SEL_IRQ_STAT)) begin
      for (int i = 0; i < IRQ_W; i++) begin
        w_irq_clr[i] = w_wr_data[i] & w_wr_be[i/8];
      end
    end
    w_irq_stat_next = (r_irq_stat & ~w_irq_clr) | w_done_vec;
  end

  // Global registers, interrupt status/output and the soft reset pulse
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_scratch    <= '0;
      r_irq_en     <= '0;
      r_irq_stat   <= '0;
      r_irq        <= 1'b0;
      r_soft_reset <= 1'b0;
    end else begin
      r_soft_reset <= w_wr_ok && (w_wr_dec.sel == SEL_CTRL) && w_wr_be[0] && w_wr_data[0];
      if (w_wr_ok && (w_wr_dec.sel == SEL_SCRATCH)) begin
        r_scratch <= apply_strb(r_scratch, w_wr_data, w_wr_be);
      end
      if (w_wr_ok && (w_wr_dec.sel == SEL_IRQ_EN)) begin
        r_irq_en <= apply_strb(r_irq_en, w_wr_data, w_wr_be);
      end
      r_irq_stat <= w_irq_stat_next;
      r_irq      <= |(r_irq_stat & r_irq_en[IRQ_W-1:0]);
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic        w_sel;
    logic [31:0] r_c2h_rd;
    logic [31:0] r_h2c_wr;
    logic [31:0] r_h2c_size;

    assign w_sel = w_wr_ok && (w_wr_dec.ch == 3'(n));

    // Host-written pointer and frame-size registers for this channel
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
        r_c2h_rd   <= '0;
        r_h2c_wr   <= '0;
        r_h2c_size <= '0;
      end else if (w_sel) begin
        case (w_wr_dec.sel)
          SEL_C2H_RD_NEXT:  r_c2h_rd   <= apply_strb(r_c2h_rd, w_wr_data, w_wr_be);
          SEL_H2C_WR_NEXT:  r_h2c_wr   <= apply_strb(r_h2c_wr, w_wr_data, w_wr_be);
          SEL_H2C_FRM_SIZE: r_h2c_size <= apply_strb(r_h2c_size, w_wr_data, w_wr_be);
          default: ;
        endcase
      end
    end

    assign c2h_rd_next[32*n +: 32]  = r_c2h_rd;
    assign h2c_wr_next[32*n +: 32]  = r_h2c_wr;
    assign h2c_frm_size[32*n +: 32] = r_h2c_size;
  end

  // Read data mux; errors are zeroed by the slave core
  always_comb begin
    w_rd_data = '0;
    case (w_rd_dec.sel)
      SEL_VERSION:  w_rd_data = VERSION;
      SEL_SCRATCH:  w_rd_data = r_scratch;
      SEL_IRQ_EN:   w_rd_data = r_irq_en;
      SEL_IRQ_STAT: w_rd_data = 32'(r_irq_stat);
      default: begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (w_rd_dec.ch == 3'(n)) begin
            case (w_rd_dec.sel)
              SEL_C2H_WR_NEXT:  w_rd_data = c2h_wr_next[32*n +: 32];
              SEL_C2H_RD_NEXT:  w_rd_data = c2h_rd_next[32*n +: 32];
              SEL_H2C_RD_NEXT:  w_rd_data = h2c_rd_next[32*n +: 32];
              SEL_H2C_WR_NEXT:  w_rd_data = h2c_wr_next[32*n +: 32];
              SEL_H2C_FRM_SIZE: w_rd_data = h2c_frm_size[32*n +: 32];
              default: ;
            endcase
          end
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_multich_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_multich_regfile
//  Description : Directed, table-driven bench for axi_lite_multich_regfile
//                with hand-written sequences for timing corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_multich_regfile;

  localparam int          NCH  = 4;
  localparam logic [1:0]  OKAY = 2'b00;
  localparam logic [1:0]  SERR = 2'b10;

  logic             clk;
  logic             aresetn;
  logic [15:0]      awaddr;
  logic             awvalid;
  logic             awready;
  logic [31:0]      wdata;
  logic [3:0]       wstrb;
  logic             wvalid;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;
  logic [15:0]      araddr;
  logic             arvalid;
  logic             arready;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;
  logic             soft_reset;
  logic             irq;
  logic [NCH*32-1:0] c2h_wr_next;
  logic [NCH*32-1:0] h2c_rd_next;
  logic [NCH-1:0]   c2h_done;
  logic [NCH-1:0]   h2c_done;
  logic [NCH*32-1:0] c2h_rd_next;
  logic [NCH*32-1:0] h2c_wr_next;
  logic [NCH*32-1:0] h2c_frm_size;

  int total = 0;
  int bad   = 0;
  int sr_cnt = 0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  axi_lite_multich_regfile #(
    .ADDR_BITS (16),
    .NUM_CH    (NCH),
    .VERSION   (32'h0002_0000)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (aresetn),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .soft_reset    (soft_reset),
    .irq           (irq),
    .c2h_wr_next   (c2h_wr_next),
    .h2c_rd_next   (h2c_rd_next),
    .c2h_done      (c2h_done),
    .h2c_done      (h2c_done),
    .c2h_rd_next   (c2h_rd_next),
    .h2c_wr_next   (h2c_wr_next),
    .h2c_frm_size  (h2c_frm_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count soft_reset high cycles
  always @(negedge clk) if (soft_reset) sr_cnt = sr_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT, got no response expected a handshake", nm);
  endtask

  // Called at a negedge; returns at a negedge after the B handshake
  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    int   n;
    logic aw_hs;
    logic w_hs;
    resp = 2'b11;
    lat  = -1;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 100) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk); n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    lat = 0;
    while (!bvalid && n < 100) begin
      @(negedge clk); n++; lat++;
    end
    if (!bvalid) begin
      awvalid = 1'b0; wvalid = 1'b0;
      timeout("write_response");
    end else begin
      resp = bresp;
      @(negedge clk);
    end
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
    int   n;
    logic ar_hs;
    d = 32'hxxxx_xxxx;
    resp = 2'b11;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arvalid && n < 100) begin
      ar_hs = arready;
      @(negedge clk); n++;
      if (ar_hs) arvalid = 1'b0;
    end
    while (!rvalid && n < 100) begin
      @(negedge clk); n++;
    end
    if (!rvalid) begin
      arvalid = 1'b0;
      timeout("read_response");
    end else begin
      d = rdata;
      resp = rresp;
      @(negedge clk);
    end
  endtask

  function automatic void addv(bit wr, logic [15:0] a, logic [31:0] d, logic [3:0] s,
                               logic [1:0] r, logic [31:0] q);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.resp = r; v.rdata = q;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          lat;

    aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    c2h_done = '0; h2c_done = '0;
    for (int n = 0; n < NCH; n++) begin
      c2h_wr_next[32*n +: 32] = 32'hC0DE_0000 | 32'(n);
      h2c_rd_next[32*n +: 32] = 32'hBEEF_0000 | 32'(n);
    end

    // Stimulus table: {write, addr, data, strb, expected resp, expected rdata}
    addv(0, 16'h000, 32'h0,         4'h0, OKAY, 32'h0002_0000);
    addv(1, 16'h008, 32'hDEADBEEF,  4'hF, OKAY, 32'h0);
    addv(0, 16'h008, 32'h0,         4'h0, OKAY, 32'hDEADBEEF);
    addv(1, 16'h008, 32'h11223344,  4'h4, OKAY, 32'h0);
    addv(0, 16'h008, 32'h0,         4'h0, OKAY, 32'hDE22BEEF);
    addv(1, 16'h00A, 32'h0,         4'hF, SERR, 32'h0);
    addv(0, 16'h008, 32'h0,         4'h0, OKAY, 32'hDE22BEEF);
    addv(0, 16'h004, 32'h0,         4'h0, SERR, 32'h0);
    addv(1, 16'h100, 32'h1,         4'hF, SERR, 32'h0);
    addv(0, 16'h100, 32'h0,         4'h0, OKAY, 32'hC0DE0000);
    addv(0, 16'h148, 32'h0,         4'h0, OKAY, 32'hBEEF0002);
    addv(1, 16'h12C, 32'h12345678,  4'hF, OKAY, 32'h0);
    addv(0, 16'h12C, 32'h0,         4'h0, OKAY, 32'h12345678);
    addv(1, 16'h170, 32'h00001000,  4'hF, OKAY, 32'h0);
    addv(0, 16'h170, 32'h0,         4'h0, OKAY, 32'h00001000);
    addv(0, 16'h182, 32'h0,         4'h0, SERR, 32'h0);
    addv(0, 16'h184, 32'h0,         4'h0, SERR, 32'h0);
    addv(1, 16'h184, 32'hFFFFFFFF,  4'hF, SERR, 32'h0);
    addv(0, 16'h114, 32'h0,         4'h0, SERR, 32'h0);
    addv(0, 16'h014, 32'h0,         4'h0, SERR, 32'h0);
    addv(1, 16'h10C, 32'hFFFFFFFF,  4'h0, OKAY, 32'h0);
    addv(0, 16'h10C, 32'h0,         4'h0, OKAY, 32'h0);
    addv(0, 16'h010, 32'h0,         4'h0, OKAY, 32'h0);
    addv(0, 16'h00C, 32'h0,         4'h0, OKAY, 32'h0);
    addv(0, 16'hFFFC, 32'h0,        4'h0, SERR, 32'h0);
    addv(1, 16'h1FC, 32'h5,         4'hF, SERR, 32'h0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_handshake", {28'd0, awready, wready, arready, bvalid}, 32'd0);
    chk("reset_resp", {24'd0, rvalid, bresp, rresp, soft_reset, irq, 1'b0}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_outbus", 32'(|{c2h_rd_next, h2c_wr_next, h2c_frm_size}), 32'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", {29'd0, awready, wready, arready}, 32'd7);

    // Table-driven accesses
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
        chk($sformatf("vec%0d_wr_%h_resp", i, vecs[i].addr), 32'(resp), 32'(vecs[i].resp));
      end else begin
        axi_read(vecs[i].addr, rd, resp);
        chk($sformatf("vec%0d_rd_%h_resp", i, vecs[i].addr), 32'(resp), 32'(vecs[i].resp));
        chk($sformatf("vec%0d_rd_%h_data", i, vecs[i].addr), rd, vecs[i].rdata);
      end
    end
    chk("h2c_wr_ch1_bus", h2c_wr_next[63:32], 32'h12345678);
    chk("frm_size_ch3_bus", h2c_frm_size[127:96], 32'h00001000);
    chk("c2h_rd_untouched", 32'(|c2h_rd_next), 32'd0);

    // Byte-strobed write with one-cycle B latency
    axi_write(16'h164, 32'hA5A5_1234, 4'b0011, resp, lat);
    chk("strb_resp", 32'(resp), 32'(OKAY));
    chk("strb_b_latency", 32'(lat), 32'd1);
    chk("strb_bus", c2h_rd_next[127:96], 32'h0000_1234);

    // Decoupled AW/W with BREADY held low
    bready = 1'b0;
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("dec_wready_low_held", 32'(wready), 32'd0);
    chk("dec_no_early_b", 32'(bvalid), 32'd0);
    repeat (2) @(negedge clk);
    awaddr = 16'h14C; awvalid = 1'b1;
    chk("dec_awready", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    chk("dec_b_not_yet", 32'(bvalid), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("dec_hold%0d", k), {29'd0, bvalid, awready, wready}, 32'd4);
      @(negedge clk);
    end
    chk("dec_bresp", 32'(bresp), 32'(OKAY));
    chk("dec_commit", h2c_wr_next[95:64], 32'hCAFE_F00D);
    bready = 1'b1;
    @(negedge clk);
    chk("dec_after_b", {29'd0, bvalid, awready, wready}, 32'd3);

    // Interrupt: set, set-wins-over-clear, strobe-gated clear, clean clear
    axi_write(16'h00C, 32'h4, 4'hF, resp, lat);
    c2h_done[1] = 1'b1;
    @(negedge clk);
    c2h_done[1] = 1'b0;
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'd1);
    axi_read(16'h010, rd, resp);
    chk("irq_stat_set", rd, 32'h4);
    awaddr = 16'h010; awvalid = 1'b1; wdata = 32'h4; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    c2h_done[1] = 1'b1;
    @(negedge clk);
    c2h_done[1] = 1'b0;
    chk("w1c_race_bvalid", 32'(bvalid), 32'd1);
    @(negedge clk);
    axi_read(16'h010, rd, resp);
    chk("w1c_race_set_wins", rd, 32'h4);
    chk("w1c_race_irq", 32'(irq), 32'd1);
    axi_write(16'h010, 32'h4, 4'b1110, resp, lat);
    axi_read(16'h010, rd, resp);
    chk("w1c_no_strobe", rd, 32'h4);
    axi_write(16'h010, 32'h4, 4'hF, resp, lat);
    axi_read(16'h010, rd, resp);
    chk("w1c_clear", rd, 32'h0);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'd0);
    h2c_done[0] = 1'b1;
    @(negedge clk);
    h2c_done[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("irq_masked", 32'(irq), 32'd0);
    axi_read(16'h010, rd, resp);
    chk("irq_stat_h2c0", rd, 32'h2);

    // Soft reset pulse
    sr_cnt = 0;
    axi_write(16'h004, 32'h1, 4'b0010, resp, lat);
    repeat (3) @(negedge clk);
    chk("soft_reset_no_strb", 32'(sr_cnt), 32'd0);
    sr_cnt = 0;
    axi_write(16'h004, 32'h1, 4'b0001, resp, lat);
    repeat (3) @(negedge clk);
    chk("soft_reset_resp", 32'(resp), 32'(OKAY));
    chk("soft_reset_cycles", 32'(sr_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_multich_regfile.md
# axi_lite_multich_regfile

AXI4-Lite register file exposing frame-buffer pointer registers for `NUM_CH` independent DMA channel pairs (C2H and H2C), plus global control, scratch and interrupt logic. It sits between the PS/host AXI-Lite master and the PL frame movers. It decodes per-channel windows, returns SLVERR on unmapped or misaligned accesses, and raises a level interrupt from sticky, write-1-to-clear frame-done status.

## Interface
- `ADDR_BITS`, 16, AXI address width; all bits are decoded.
- `NUM_CH`, 4, number of channels, 1..8.
- `VERSION`, 32'h0002_0000, value returned by the VERSION register.
- `s_axi_aclk`  in  1  clock.
- `s_axi_aresetn`  in  1  reset, asynchronous, active-low.
- `s_axi_aw*` (addr/valid/ready), `s_axi_w*` (data 32 / strb 4 / valid / ready), `s_axi_b*` (resp 2 / valid / ready): AXI4-Lite write channels.
- `s_axi_ar*`, `s_axi_r*` (data 32 / resp 2 / valid / ready): AXI4-Lite read channels.
- `soft_reset`  out  1  one-cycle pulse.
- `irq`  out  1  level interrupt.
- `c2h_wr_next`  in  NUM_CH*32  per-channel FPGA write pointer, read-only.
- `h2c_rd_next`  in  NUM_CH*32  per-channel FPGA read pointer, read-only.
- `c2h_done`, `h2c_done`  in  NUM_CH  per-channel frame-done pulses.
- `c2h_rd_next`, `h2c_wr_next`, `h2c_frm_size`  out  NUM_CH*32  host-written registers. Channel n occupies bits [32n+31:32n].

## Operation
- Global map:
  - 0x000 VERSION (RO).
  - 0x004 CTRL (WO). Writing bit0=1 with strb[0] set fires `soft_reset`. Reads return 0.
  - 0x008 SCRATCH (RW).
  - 0x00C IRQ_EN (RW), bits [2n]=c2h and [2n+1]=h2c for channel n.
  - 0x010 IRQ_STAT (W1C), same bit layout.
- Channel n window, base 0x100 + n*0x20:
  - +0x00 C2H_WR_NEXT (RO).
  - +0x04 C2H_RD_NEXT (RW).
  - +0x08 H2C_RD_NEXT (RO).
  - +0x0C H2C_WR_NEXT (RW).
  - +0x10 H2C_FRM_SIZE (RW).
  - +0x14..+0x1C are unmapped.
- Byte strobes apply to every RW register. A W1C bit is cleared only where its strobe byte is set.
- An access is an error (SLVERR, 2'b10) if any of these hold:
  - addr[1:0]≠0;
  - channel index ≥ NUM_CH;
  - the offset is unmapped;
  - a write targets an RO register;
  - a read targets CTRL.
- An error write changes no state. An error read returns RDATA=0.
- IRQ_STAT bit set: the corresponding `*_done` pulse is high at a clock edge.
- Set and W1C clear on the same edge: the set wins.
- `irq` = |(IRQ_STAT & IRQ_EN), registered.
- Reset values:
  - all registers, `soft_reset`, `irq`, BVALID, RVALID, BRESP, RRESP and RDATA are 0;
  - AWREADY, WREADY and ARREADY are 1 once reset is released.

## Timing
- Write path:
  - AW and W are accepted independently. AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - At the first edge where both are held and BVALID=0, the register commits, BVALID rises and both holds clear.
  - AW+W handshake at edge T → commit and BVALID at T+1 → next accept at the edge after the B handshake.
  - One outstanding write at a time. BVALID holds until BREADY.
- `soft_reset` is high for exactly the cycle after the commit edge.
- Read path:
  - ARREADY = !RVALID.
  - AR handshake at edge T → RDATA/RRESP captured at T, RVALID high from T.
  - RVALID holds with stable data until RREADY.
  - RO inputs are sampled at edge T.
- Reads and writes are fully concurrent. A read of a register that commits on the same edge returns the old value.
- Reset asserted mid-transaction aborts everything immediately. Pending holds are lost and no B/R response is produced.

## Structure
- Package `axi_lite_regfile_pkg`: register offsets, CH_BASE=0x100, CH_STRIDE=0x20, RESP_OKAY/RESP_SLVERR, and the default VERSION.
- Sub-module `axi_lite_slv_core`: AW/W/B/AR/R handshake and hold logic. It presents `wr_en`/`wr_addr`/`wr_data`/`wr_be` with `wr_err` back, and `rd_en`/`rd_addr` with `rd_data`/`rd_err` back.
- The top level contains the decode, register array, IRQ logic and packed-bus unpacking.

## Test plan
- **Reset and ID.** Release reset, then read 0x000 → RDATA=32'h0002_0000, RRESP=0. All outputs were 0 during reset.
- **Byte-strobed write.** With NUM_CH=4, write 0x164 (ch3 C2H_RD_NEXT) = 0xA5A5_1234, strb=4'b0011 → `c2h_rd_next[127:96]`=0x0000_1234, BRESP=0, BVALID one cycle after the simultaneous AW/W handshake.
- **Decoupled AW/W.** Present W 3 cycles before AW, and hold BREADY low for 5 cycles → one commit, BVALID held, AWREADY/WREADY low until the B handshake.
- **Error accesses.** Write 0x100 (RO); read 0x182 (misaligned); read 0x184 with NUM_CH=4 → SLVERR each time, RDATA=0, no register change.
- **Interrupts.** Pulse `c2h_done[1]` with IRQ_EN=0x4 → IRQ_STAT=0x4, `irq`=1. Then W1C 0x4 on the same edge as a new pulse → bit stays set. A clean W1C → `irq`=0.
- **Soft reset.** Write CTRL=1 → `soft_reset` high for exactly 1 cycle. A read of CTRL → SLVERR.
